reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register index width (2**ADDR_WIDTH registers).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port ReadReg1  input  ADDR_WIDTH  read port 1 index (rs).
REQ-006 Port ReadReg2  input  ADDR_WIDTH  read port 2 index (rt).
REQ-007 Port Use1 / Use2  input  1 each  instruction consumes read port 1 / 2.
REQ-008 Port WriteReg  input  ADDR_WIDTH  write-back index, output of the rt/rd destination select.
REQ-009 Port RegWrite  input  1  write enable.
REQ-010 Port WriteData  input  DATA_WIDTH  write-back value.
REQ-011 Port IssueValid  input  1  long-latency op issued; its destination becomes pending.
REQ-012 Port IssueReg  input  ADDR_WIDTH  destination of issued op.
REQ-013 Port ReadData1 / ReadData2  output  DATA_WIDTH each  read values.
REQ-014 Port Stall  output  1  a used source register is pending.
REQ-015 Port PendingCount  output  ADDR_WIDTH+1  number of pending registers, registered.

Function
REQ-016 Reads SHALL be combinational; ReadDataN = regs[ReadRegN]; index 0 SHALL always read 0.
REQ-017 On a rising edge with RegWrite=1 and WriteReg!=0, regs[WriteReg] SHALL take WriteData; writes to index 0 SHALL be discarded.
REQ-018 On a rising edge with IssueValid=1 and IssueReg!=0, busy[IssueReg] SHALL be set; issue to 0 SHALL be ignored.
REQ-019 A qualifying write (REQ-017) SHALL clear busy[WriteReg] on the same edge.
REQ-020 Issue and write to the same register on one edge: busy SHALL remain set (issue wins); data SHALL still be written.
REQ-021 Stall SHALL equal (Use1 & busy[ReadReg1]) | (Use2 & busy[ReadReg2]), combinational; index 0 never busy.
REQ-022 PendingCount SHALL be +1 on issue to a non-busy register, -1 on a write clearing a busy register (not re-issued the same edge), net of both when simultaneous, unchanged for re-issue of an already-busy register.
REQ-023 PendingCount SHALL equal the popcount of busy at all times and SHALL never wrap.

Reset
REQ-024 With rst=1 at an edge, all registers, all busy bits and PendingCount SHALL become 0; rst SHALL override same-edge RegWrite and IssueValid.
REQ-025 After reset ReadData1/2 SHALL be 0 and Stall 0 for all indices.

Configuration
REQ-026 Macro REG_BYPASS_EN SHALL control write-to-read forwarding.
REQ-027 With REG_BYPASS_EN defined: if RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN, ReadDataN SHALL be WriteData the same cycle, and that port SHALL not contribute to Stall.
REQ-028 Without REG_BYPASS_EN: ReadDataN SHALL return the pre-edge value; write visible the cycle after; Stall per REQ-021 only.

Structure
REQ-029 Shared package mips_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults and constant REG_ZERO (index 0).
REQ-030 Busy-bit and PendingCount logic SHALL be sub-module reg_scoreboard; storage and read muxing stay in reg_file.

Verification
REQ-031 Reset, then read all 32 indices -> every ReadData 0, Stall 0, PendingCount 0.
REQ-032 Write 0xDEADBEEF to r5, then ReadReg1=5 -> 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-033 Same cycle RegWrite r7=0xA5A5A5A5, ReadReg2=7 -> 0xA5A5A5A5 with REG_BYPASS_EN, old value without.
REQ-034 Issue r9, ReadReg1=9 Use1=1 -> Stall 1, PendingCount 1; Use1=0 -> Stall 0; write r9 -> Stall 0, count 0.
REQ-035 Issue r3 and write r3 same edge -> busy stays, count 1; re-issue r3 -> count stays 1; issue r0 -> count unchanged.
REQ-036 Issue r2,r4 then assert rst with RegWrite r2 -> count 0, r2 reads 0, Stall 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared defaults for the register-file slice: widths and the hard-wired zero index.
package mips_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int REG_ZERO           = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit tracking for long-latency destinations plus a registered pending count
// that always equals the popcount of the busy vector.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [ADDR_WIDTH-1:0]     write_reg,
  input  logic                      issue_en,
  input  logic [ADDR_WIDTH-1:0]     issue_reg,
  output logic [2**ADDR_WIDTH-1:0]  busy,
  output logic [ADDR_WIDTH:0]       pending_count
);
  localparam int NREG = 2**ADDR_WIDTH;

  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic [ADDR_WIDTH:0] count_reg;
  logic [ADDR_WIDTH:0] count_next;
  logic write_q;
  logic issue_q;
  logic inc;
  logic dec;

  assign write_q = write_en && (write_reg != ADDR_WIDTH'(REG_ZERO));
  assign issue_q = issue_en && (issue_reg != ADDR_WIDTH'(REG_ZERO));

  // Issue is applied after the write-back clear, so a same-edge pair leaves the bit set.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == REG_ZERO) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        assign busy_next[gi] = (issue_q && (issue_reg == ADDR_WIDTH'(gi))) ||
                               (busy_reg[gi] && !(write_q && (write_reg == ADDR_WIDTH'(gi))));
      end
    end
  endgenerate

  always_comb begin
    inc        = issue_q && !busy_reg[issue_reg];
    dec        = write_q && busy_reg[write_reg] && !(issue_q && (issue_reg == write_reg));
    count_next = count_reg + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg  <= '0;
      count_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      count_reg <= count_next;
    end
  end

  assign busy          = busy_reg;
  assign pending_count = count_reg;
endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with index 0 hard-wired to zero and a busy scoreboard.
// Optional same-cycle write-to-read forwarding when REG_BYPASS_EN is defined.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic                  Use1,
  input  logic                  Use2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic                  RegWrite,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueReg,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Stall,
  output logic [ADDR_WIDTH:0]   PendingCount
);
  localparam int NREG = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]       busy;
  logic                  write_q;
  logic                  fwd1;
  logic                  fwd2;

  assign write_q = RegWrite && (WriteReg != ADDR_WIDTH'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write_q) begin
      regs[WriteReg] <= WriteData;
    end
  end

`ifdef REG_BYPASS_EN
  assign fwd1 = write_q && (WriteReg == ReadReg1);
  assign fwd2 = write_q && (WriteReg == ReadReg2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (fwd1) ReadData1 = WriteData;
    else if (ReadReg1 != ADDR_WIDTH'(REG_ZERO)) ReadData1 = regs[ReadReg1];
    if (fwd2) ReadData2 = WriteData;
    else if (ReadReg2 != ADDR_WIDTH'(REG_ZERO)) ReadData2 = regs[ReadReg2];
  end

  // A forwarded operand is satisfied this cycle, so it cannot stall.
  assign Stall = (Use1 && busy[ReadReg1] && !fwd1) || (Use2 && busy[ReadReg2] && !fwd2);

  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .write_en      (RegWrite),
    .write_reg     (WriteReg),
    .issue_en      (IssueValid),
    .issue_reg     (IssueReg),
    .busy          (busy),
    .pending_count (PendingCount)
  );
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard-driven bench for reg_file; expectations depend on REG_BYPASS_EN.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg, IssueReg;
  logic        Use1, Use2, RegWrite, IssueValid;
  logic [31:0] WriteData, ReadData1, ReadData2;
  logic        Stall;
  logic [5:0]  PendingCount;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

`ifdef REG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .Use1(Use1), .Use2(Use2), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .WriteData(WriteData), .IssueValid(IssueValid), .IssueReg(IssueReg),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Stall(Stall),
    .PendingCount(PendingCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check({tag, "_noexp"}, obs, 32'hxxxx_xxxx);
    else check(tag, obs, exp_q.pop_front());
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; IssueValid = 0; Use1 = 0; Use2 = 0;
  endtask

  initial begin
    rst = 1; idle(); ReadReg1 = 0; ReadReg2 = 0; WriteReg = 0; IssueReg = 0; WriteData = 0;
    // Reset with write/issue pending to confirm reset dominates.
    RegWrite = 1; WriteReg = 1; WriteData = 32'hFFFF_FFFF; IssueValid = 1; IssueReg = 1;
    cyc(); cyc();
    rst = 0; idle();

    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i); Use1 = 1; Use2 = 1; #1;
      push(0); push(0); push(0);
      compare($sformatf("rst_rd1_r%0d", i), ReadData1);
      compare($sformatf("rst_rd2_r%0d", 31 - i), ReadData2);
      compare($sformatf("rst_stall_%0d", i), 32'(Stall));
    end
    push(0); compare("rst_count", 32'(PendingCount));
    idle();

    RegWrite = 1; WriteReg = 5; WriteData = 32'hDEAD_BEEF; cyc();
    RegWrite = 0; ReadReg1 = 5; #1;
    push(32'hDEAD_BEEF); compare("r5_read", ReadData1);
    RegWrite = 1; WriteReg = 0; WriteData = 32'h1234; cyc();
    RegWrite = 0; ReadReg1 = 0; ReadReg2 = 5; #1;
    push(0); compare("r0_read", ReadData1);
    push(32'hDEAD_BEEF); compare("r5_keep", ReadData2);

    RegWrite = 1; WriteReg = 7; WriteData = 32'h1111_1111; cyc();
    WriteData = 32'hA5A5_A5A5; ReadReg2 = 7; #1;
    push(BYPASS ? 32'hA5A5_A5A5 : 32'h1111_1111); compare("r7_same_cycle", ReadData2);
    cyc(); RegWrite = 0; #1;
    push(32'hA5A5_A5A5); compare("r7_next_cycle", ReadData2);

    IssueValid = 1; IssueReg = 9; cyc(); IssueValid = 0;
    ReadReg1 = 9; Use1 = 1; #1;
    push(1); compare("r9_stall", 32'(Stall));
    push(1); compare("r9_count", 32'(PendingCount));
    Use1 = 0; #1;
    push(0); compare("r9_unused", 32'(Stall));
    Use1 = 1; RegWrite = 1; WriteReg = 9; WriteData = 32'h99; #1;
    push(BYPASS ? 0 : 1); compare("r9_wb_stall", 32'(Stall));
    cyc(); RegWrite = 0; #1;
    push(0); compare("r9_cleared", 32'(Stall));
    push(0); compare("r9_count0", 32'(PendingCount));
    push(32'h99); compare("r9_data", ReadData1);
    idle();

    IssueValid = 1; IssueReg = 3; RegWrite = 1; WriteReg = 3; WriteData = 32'h33; cyc();
    idle(); ReadReg1 = 3; Use1 = 1; #1;
    push(1); compare("r3_count", 32'(PendingCount));
    push(1); compare("r3_busy", 32'(Stall));
    push(32'h33); compare("r3_data", ReadData1);
    IssueValid = 1; IssueReg = 3; cyc();
    push(1); compare("r3_reissue", 32'(PendingCount));
    IssueReg = 0; cyc(); IssueValid = 0;
    push(1); compare("r0_issue", 32'(PendingCount));
    Use1 = 0; ReadReg2 = 0; Use2 = 1; #1;
    push(0); compare("r0_stall", 32'(Stall));
    idle(); RegWrite = 1; WriteReg = 3; WriteData = 32'h3; cyc(); RegWrite = 0;
    push(0); compare("r3_wb_count", 32'(PendingCount));

    IssueValid = 1; IssueReg = 2; cyc();
    IssueReg = 4; cyc(); IssueValid = 0;
    push(2); compare("r2r4_count", 32'(PendingCount));
    rst = 1; RegWrite = 1; WriteReg = 2; WriteData = 32'h22; IssueValid = 1; IssueReg = 6; cyc();
    rst = 0; idle();
    ReadReg1 = 2; ReadReg2 = 4; Use1 = 1; Use2 = 1; #1;
    push(0); compare("rst2_count", 32'(PendingCount));
    push(0); compare("rst2_r2", ReadData1);
    push(0); compare("rst2_stall", 32'(Stall));
    ReadReg1 = 5; ReadReg2 = 6; #1;
    push(0); compare("rst2_r5", ReadData1);
    push(0); compare("rst2_r6_stall", 32'(Stall));

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
